banner_scroll_ctrl: RTL and testbench
=====================================

Name: banner_scroll_ctrl

Overview:
Sequencer for the banner-word bitmap ROM, which has 15 rows of 71-bit words and a registered address with 1-cycle read latency. Per frame it walks ROM rows 0..ROWS-1 and extracts a WIN_W-column window at the current horizontal scroll offset. Each windowed row is presented to the LED-matrix row driver over a valid/ready handshake. The scroll offset advances once every STEP_FRAMES frames, wrapping around the word, so the banner scrolls continuously.

Parameters:
ROWS, 15, number of ROM rows per frame (addresses 0..ROWS-1)
WORD_W, 71, ROM word width in pixel columns
WIN_W, 16, visible window width; 1 <= WIN_W <= WORD_W
STEP_FRAMES, 4, frames per one-column scroll step; must be >= 1
READ_LAT, 1, ROM read latency in cycles, counted from rom_addr change to rom_data valid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep producing frames
frame_req  in  1  pulse/level from the display: ready to start a new frame
rom_addr  out  5  ROM address, registered
rom_data  in  WORD_W  ROM read data
row_valid  out  1  row_pix/row_idx valid
row_ready  in  1  driver accepts the row
row_idx  out  4  current row number
row_pix  out  WIN_W  windowed pixels; MSB = leftmost column
frame_done  out  1  1-cycle pulse after the last row of a frame is accepted
busy  out  1  FSM not in IDLE
scroll_pos  out  7  current offset, 0..WORD_W-1

Behaviour:
- Reset (async, rst_n=0) forces all outputs and state to 0:
  - rom_addr, row_valid, row_idx, row_pix, frame_done, busy, scroll_pos all 0.
  - frame counter 0; FSM IDLE.
- Asserting reset mid-frame aborts the frame immediately; no frame_done is produced.
- FSM states: IDLE, WAIT_FRAME, ADDR, WAIT_ROM, PRESENT, END.
- IDLE: when run=1, go to WAIT_FRAME.
- WAIT_FRAME:
  - if run=0, go to IDLE;
  - else if frame_req=1, set row counter to 0, rom_addr<=0, go to ADDR.
- ADDR: rom_addr is stable. Count READ_LAT cycles via WAIT_ROM, so rom_data is sampled exactly READ_LAT+1 cycles after rom_addr was updated.
- WAIT_ROM (final latency cycle):
  - register row_pix from rom_data;
  - row_idx <= row counter; row_valid <= 1; go to PRESENT.
- Window rule: row_pix[WIN_W-1-i] = rom_data[WORD_W-1-((scroll_pos+i) mod WORD_W)] for i = 0..WIN_W-1.
  - The modulo is implemented as a single conditional subtract of WORD_W, since scroll_pos+i < 2*WORD_W.
- PRESENT:
  - row_valid, row_pix and row_idx are held stable until row_ready=1; row_ready while valid=1 is a transfer.
  - On transfer, row_valid <= 0.
  - If the row counter = ROWS-1, go to END; otherwise increment the counter, rom_addr <= counter+1, go to ADDR.
- END:
  - frame_done=1 for this one cycle.
  - Frame counter increments; when it reaches STEP_FRAMES-1 it clears and scroll_pos advances by one (ROWS-1... see wrap rule).
  - Scroll wrap: scroll_pos = WORD_W-1 wraps to 0.
  - Go to WAIT_FRAME.
- run=0 mid-frame: the current frame completes normally; IDLE is entered from WAIT_FRAME.
- frame_req is ignored outside WAIT_FRAME.
- scroll_pos changes only in END, so it is constant within a frame (no tearing).
- busy = (state != IDLE).
- Per-row throughput with row_ready tied high: READ_LAT+2 cycles.

Optional Feature:
BANNER_SCROLL_BOUNCE_EN
- Defined: ping-pong scroll.
  - A direction register (reset = forward) is added.
  - scroll_pos moves forward up to WORD_W-WIN_W, then reverses down to 0, then reverses again; it never wraps.
  - Window indices therefore never exceed WORD_W-1, and the subtract path is removed.
- Undefined: wrap-around scroll as specified in Behaviour.

Decomposition:
- Package banner_pkg holds:
  - FSM state enum;
  - BANNER_ROWS=15 and BANNER_WORD_W=71 constants;
  - scroll and row counter widths derived with $clog2.
- Sub-module banner_window_sel (combinational): takes rom_data and scroll_pos and produces the WIN_W window. It is shared with any future static-display controller.

Test Plan:
- Reset, then run=1 and frame_req pulse at scroll_pos=0, row_ready=1:
  - row 0 row_pix=0x0000; row 3 = 0xC003;
  - rows appear every 3 cycles; frame_done once after row 14.
- STEP_FRAMES=1, second frame (scroll_pos=1): row 3 row_pix=0x8007.
- Drive scroll_pos to 70 (70 frames, STEP_FRAMES=1):
  - row 3 row_pix=0x6001 (wrap);
  - the next frame END sets scroll_pos=0.
- Backpressure: hold row_ready=0 for 10 cycles on row 5.
  - row_valid, row_pix and row_idx=5 stay stable; rom_addr does not advance.
  - Row 6 follows 3 cycles after acceptance.
- Drop run to 0 during row 7: frame completes through row 14 with frame_done; IDLE is then entered and busy=0.
- Assert rst_n=0 during WAIT_ROM of row 9: all outputs are 0 asynchronously, with no frame_done.
  - After release, with run=1 and frame_req, the frame restarts at row 0 with scroll_pos=0.

Source files
------------

// File: rtl/banner_pkg.sv
// Shared types and constants for the banner scroll sequencer.
package banner_pkg;

  localparam int unsigned BANNER_ROWS       = 15;
  localparam int unsigned BANNER_WORD_W     = 71;
  localparam int unsigned BANNER_WIN_W      = 16;
  localparam int unsigned BANNER_ROM_ADDR_W = 5;
  localparam int unsigned BANNER_ROW_W      = $clog2(BANNER_ROWS);
  localparam int unsigned BANNER_SCROLL_W   = $clog2(BANNER_WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_ADDR       = 3'd2,
    ST_WAIT_ROM   = 3'd3,
    ST_PRESENT    = 3'd4,
    ST_END        = 3'd5
  } banner_state_e;

endpackage

// File: rtl/banner_window_sel.sv
// Combinational column-window extractor: picks WIN_W columns of a ROM word
// starting at scroll_pos, leftmost column in the MSB.
// BANNER_SCROLL_BOUNCE_EN: scroll_pos never exceeds WORD_W-WIN_W, so the
// wrap subtract is dropped.
module banner_window_sel #(
  parameter int unsigned WORD_W = 71,
  parameter int unsigned WIN_W  = 16
) (
  input  logic [WORD_W-1:0]         rom_data,
  input  logic [$clog2(WORD_W)-1:0] scroll_pos,
  output logic [WIN_W-1:0]          win_c
);

  localparam int unsigned SEL_W = $clog2(WORD_W);

  // One mux per output column; column index is (scroll_pos + i) mod WORD_W.
  for (genvar i = 0; i < WIN_W; i++) begin : g_col
    logic [SEL_W-1:0] col;
`ifdef BANNER_SCROLL_BOUNCE_EN
    assign col = scroll_pos + SEL_W'(i);
`else
    localparam int unsigned SUM_W = $clog2(2 * WORD_W);
    logic [SUM_W-1:0] sum;
    assign sum = SUM_W'(scroll_pos) + SUM_W'(i);
    assign col = (sum >= SUM_W'(WORD_W)) ? SEL_W'(sum - SUM_W'(WORD_W)) : SEL_W'(sum);
`endif
    assign win_c[WIN_W-1-i] = rom_data[SEL_W'(WORD_W-1) - col];
  end

endmodule

// File: rtl/banner_scroll_ctrl.sv
// Banner ROM sequencer: walks ROM rows each frame, windows each row at the
// current scroll offset and hands it to the row driver over valid/ready.
// BANNER_SCROLL_BOUNCE_EN: ping-pong scroll instead of wrap-around.
module banner_scroll_ctrl
  import banner_pkg::*;
#(
  parameter int unsigned ROWS        = BANNER_ROWS,
  parameter int unsigned WORD_W      = BANNER_WORD_W,
  parameter int unsigned WIN_W       = BANNER_WIN_W,
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         frame_req,
  output logic [BANNER_ROM_ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0]            rom_data,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [BANNER_ROW_W-1:0]      row_idx,
  output logic [WIN_W-1:0]             row_pix,
  output logic                         frame_done,
  output logic                         busy,
  output logic [BANNER_SCROLL_W-1:0]   scroll_pos
);

  localparam int unsigned ADDR_W   = BANNER_ROM_ADDR_W;
  localparam int unsigned ROW_W    = BANNER_ROW_W;
  localparam int unsigned SCROLL_W = BANNER_SCROLL_W;
  localparam int unsigned LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned FRAME_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  banner_state_e        state_q, state_d;
  logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SCROLL_W-1:0]  scroll_q, scroll_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic                 row_valid_q, row_valid_d;
  logic [ROW_W-1:0]     row_idx_q, row_idx_d;
  logic [WIN_W-1:0]     row_pix_q, row_pix_d;
  logic                 frame_done_q, frame_done_d;
  logic                 busy_q, busy_d;
  logic [WIN_W-1:0]     win_c;
`ifdef BANNER_SCROLL_BOUNCE_EN
  localparam int unsigned MAX_POS = WORD_W - WIN_W;
  logic                 dir_q, dir_d;   // 0 = forward, 1 = backward
`endif

  banner_window_sel #(
    .WORD_W (WORD_W),
    .WIN_W  (WIN_W)
  ) u_window_sel (
    .rom_data   (rom_data),
    .scroll_pos (scroll_q),
    .win_c      (win_c)
  );

  // Next-state and next-output logic for the row sequencer.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    scroll_d     = scroll_q;
    rom_addr_d   = rom_addr_q;
    row_valid_d  = row_valid_q;
    row_idx_d    = row_idx_q;
    row_pix_d    = row_pix_q;
    frame_done_d = 1'b0;
`ifdef BANNER_SCROLL_BOUNCE_EN
    dir_d        = dir_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (frame_req) begin
          row_cnt_d  = '0;
          rom_addr_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        lat_cnt_d = '0;
        state_d   = ST_WAIT_ROM;
      end
      ST_WAIT_ROM: begin
        if (lat_cnt_q == LAT_W'(READ_LAT - 1)) begin
          row_pix_d   = win_c;
          row_idx_d   = row_cnt_q;
          row_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_PRESENT: begin
        if (row_ready) begin
          row_valid_d = 1'b0;
          if (row_cnt_q == ROW_W'(ROWS - 1)) begin
            frame_done_d = 1'b1;
            state_d      = ST_END;
          end else begin
            row_cnt_d  = row_cnt_q + ROW_W'(1);
            rom_addr_d = ADDR_W'(row_cnt_q) + ADDR_W'(1);
            state_d    = ST_ADDR;
          end
        end
      end
      ST_END: begin
        state_d = ST_WAIT_FRAME;
        if (frame_cnt_q == FRAME_W'(STEP_FRAMES - 1)) begin
          frame_cnt_d = '0;
`ifdef BANNER_SCROLL_BOUNCE_EN
          if (!dir_q) begin
            if (scroll_q >= SCROLL_W'(MAX_POS)) begin
              dir_d = 1'b1;
              if (scroll_q != '0) scroll_d = scroll_q - SCROLL_W'(1);
            end else begin
              scroll_d = scroll_q + SCROLL_W'(1);
            end
          end else begin
            if (scroll_q == '0) begin
              dir_d = 1'b0;
              if (MAX_POS != 0) scroll_d = SCROLL_W'(1);
            end else begin
              scroll_d = scroll_q - SCROLL_W'(1);
            end
          end
`else
          if (scroll_q == SCROLL_W'(WORD_W - 1)) scroll_d = '0;
          else                                   scroll_d = scroll_q + SCROLL_W'(1);
`endif
        end else begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      scroll_q     <= '0;
      rom_addr_q   <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      row_pix_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BANNER_SCROLL_BOUNCE_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      scroll_q     <= scroll_d;
      rom_addr_q   <= rom_addr_d;
      row_valid_q  <= row_valid_d;
      row_idx_q    <= row_idx_d;
      row_pix_q    <= row_pix_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef BANNER_SCROLL_BOUNCE_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign rom_addr   = rom_addr_q;
  assign row_valid  = row_valid_q;
  assign row_idx    = row_idx_q;
  assign row_pix    = row_pix_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign scroll_pos = scroll_q;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl: one instance steps every frame,
// a second (same stimulus) steps every 4 frames.
module tb_banner_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        frame_req;
  logic        row_ready;

  logic [4:0]  rom_addr_a, rom_addr_b;
  logic [70:0] rom_data_a, rom_data_b;
  logic        row_valid_a, row_valid_b;
  logic [3:0]  row_idx_a, row_idx_b;
  logic [15:0] row_pix_a, row_pix_b;
  logic        frame_done_a, frame_done_b;
  logic        busy_a, busy_b;
  logic [6:0]  scroll_pos_a, scroll_pos_b;

  int checks   = 0;
  int failures = 0;
  int exp_a    = 0;
  int exp_b    = 0;
  int frames_b = 0;
  logic [15:0] cap3;

  always #5 clk = ~clk;

  banner_scroll_ctrl #(.STEP_FRAMES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_req(frame_req),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .row_valid(row_valid_a), .row_ready(row_ready),
    .row_idx(row_idx_a), .row_pix(row_pix_a),
    .frame_done(frame_done_a), .busy(busy_a), .scroll_pos(scroll_pos_a)
  );

  banner_scroll_ctrl #(.STEP_FRAMES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .frame_req(frame_req),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .row_valid(row_valid_b), .row_ready(row_ready),
    .row_idx(row_idx_b), .row_pix(row_pix_b),
    .frame_done(frame_done_b), .busy(busy_b), .scroll_pos(scroll_pos_b)
  );

  // ROM contents: row 3 has columns 0,1,14,15,16 lit; other rows a fixed pattern.
  function automatic logic [70:0] rom_word(input int r);
    logic [70:0] w;
    w = '0;
    if (r == 3) begin
      w[70] = 1'b1; w[69] = 1'b1; w[56] = 1'b1; w[55] = 1'b1; w[54] = 1'b1;
    end else if (r < 15) begin
      for (int j = 0; j < 71; j++) w[7'(j)] = (((j * 7 + r * 5) % 11) < (r % 4));
    end
    return w;
  endfunction

  function automatic logic [15:0] win_ref(input logic [70:0] w, input int pos);
    logic [15:0] v;
    int k;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      k = 70 - ((pos + i) % 71);
      v[4'(15 - i)] = w[7'(k)];
    end
    return v;
  endfunction

  // ROM with registered address, one cycle of read latency.
  always @(posedge clk) begin
    rom_data_a <= rom_word(int'(rom_addr_a));
    rom_data_b <= rom_word(int'(rom_addr_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rom_addr"},   32'(rom_addr_a),   32'd0);
    check({tag, "_row_valid"},  32'(row_valid_a),  32'd0);
    check({tag, "_row_idx"},    32'(row_idx_a),    32'd0);
    check({tag, "_row_pix"},    32'(row_pix_a),    32'd0);
    check({tag, "_frame_done"}, 32'(frame_done_a), 32'd0);
    check({tag, "_busy"},       32'(busy_a),       32'd0);
    check({tag, "_scroll_a"},   32'(scroll_pos_a), 32'd0);
    check({tag, "_scroll_b"},   32'(scroll_pos_b), 32'd0);
  endtask

  // Runs one frame from WAIT_FRAME; returns early when abort_row is reached
  // with the DUT sitting in WAIT_ROM for that row.
  task automatic run_frame(input int hold_row, input int drop_row, input int abort_row,
                           output logic [15:0] row3);
    int gap;
    bit stable;
    bit early_done;
    logic [15:0] hp;
    logic [3:0]  hi;
    logic [4:0]  ha;
    row3 = '0;
    early_done = 1'b0;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    for (int r = 0; r < 15; r++) begin
      if (r == abort_row) begin
        tick();
        tick();
        check("abort_rom_addr", 32'(rom_addr_a), 32'(r));
        check("abort_valid_low", 32'(row_valid_a), 32'd0);
        return;
      end
      gap = 0;
      do begin
        tick();
        gap++;
        if (frame_done_a) early_done = 1'b1;
      end while (!row_valid_a && gap < 20);
      if (!row_valid_a) begin
        check("row_valid_timeout", 32'(row_valid_a), 32'd1);
        return;
      end
      if (r > 0) check("row_gap", 32'(gap), 32'd3);
      check("row_idx", 32'(row_idx_a), 32'(r));
      check("row_pix", 32'(row_pix_a), 32'(win_ref(rom_word(r), exp_a)));
      if (r == 3) row3 = row_pix_a;
      if (r == 0) begin
        check("frame_scroll_a", 32'(scroll_pos_a), 32'(exp_a));
        check("frame_scroll_b", 32'(scroll_pos_b), 32'(exp_b));
      end
      if (r == drop_row) run = 1'b0;
      if (r == hold_row) begin
        row_ready = 1'b0;
        hp = row_pix_a;
        hi = row_idx_a;
        ha = rom_addr_a;
        check("hold_rom_addr", 32'(rom_addr_a), 32'(r));
        stable = 1'b1;
        repeat (10) begin
          tick();
          if (!(row_valid_a && row_pix_a == hp && row_idx_a == hi && rom_addr_a == ha))
            stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        row_ready = 1'b1;
      end
    end
    tick();
    check("frame_done_a_hi", 32'(frame_done_a), 32'd1);
    check("frame_done_b_hi", 32'(frame_done_b), 32'd1);
    check("no_early_done", 32'(early_done), 32'd0);
    tick();
    check("frame_done_lo", 32'(frame_done_a), 32'd0);
    exp_a = (exp_a + 1) % 71;
    frames_b++;
    if (frames_b % 4 == 0) exp_b = (exp_b + 1) % 71;
    check("end_scroll_a", 32'(scroll_pos_a), 32'(exp_a));
    check("end_scroll_b", 32'(scroll_pos_b), 32'(exp_b));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    frame_req = 1'b0;
    row_ready = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy_a), 32'd0);
    run = 1'b1;
    tick();
    check("wait_frame_busy", 32'(busy_a), 32'd1);

    // Frame at scroll 0, then scroll 1.
    run_frame(-1, -1, -1, cap3);
    check("row3_pos0", 32'(cap3), 32'h0000_C003);
    run_frame(-1, -1, -1, cap3);
    check("row3_pos1", 32'(cap3), 32'h0000_8007);

    // Advance to scroll 70 and check the wrapping window and scroll wrap.
    for (int f = 3; f <= 70; f++) run_frame(-1, -1, -1, cap3);
    check("scroll_at_70", 32'(scroll_pos_a), 32'd70);
    run_frame(-1, -1, -1, cap3);
    check("row3_pos70", 32'(cap3), 32'h0000_6001);
    check("scroll_wrapped", 32'(scroll_pos_a), 32'd0);

    // Backpressure on row 5, run dropped during row 7.
    run_frame(5, 7, -1, cap3);
    tick();
    check("idle_after_drop_busy", 32'(busy_a), 32'd0);
    check("idle_after_drop_valid", 32'(row_valid_a), 32'd0);
    tick();
    check("idle_stays", 32'(busy_a), 32'd0);

    // Reset during WAIT_ROM of row 9.
    run = 1'b1;
    tick();
    check("restart_busy", 32'(busy_a), 32'd1);
    run_frame(-1, -1, 9, cap3);
    check("pre_reset_scroll", 32'(scroll_pos_a), 32'(exp_a));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    tick();
    check("reset_no_done", 32'(frame_done_a), 32'd0);
    exp_a    = 0;
    exp_b    = 0;
    frames_b = 0;
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy_a), 32'd1);
    run_frame(-1, -1, -1, cap3);
    check("post_reset_row3", 32'(cap3), 32'h0000_C003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
